demux_1_to_4_nb: RTL and testbench

Buffered N-bit 1-to-4 demultiplexer. It is the distribution end of the 4-to-1 selection path and routes a single handshaked input stream to one of four output channels (A, B, C, D). Each channel is a one-entry holding register with its own valid/ack handshake, so a slow consumer stalls only writes aimed at its own channel. It sits between a single producer and four independent consumers.

---
 rtl/demux_1_to_4_nb.sv | 108 ++++++++++
 tb/tb_demux_1_to_4_nb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_4_nb.sv
// Buffered 1-to-4 demultiplexer: one handshaked input stream routed into four one-entry channels.
// Optional DEMUX_ROUND_ROBIN_EN: destination comes from an internal rotating pointer instead of S.
module demux_1_to_4_nb #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic [1:0]   S,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic [N-1:0] D,
  output logic [3:0]   valid,
  input  logic [3:0]   ack
);

  localparam int unsigned NCH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e  state_q [NCH];
  chan_state_e  state_d [NCH];
  logic [N-1:0] data_q  [NCH];
  logic [N-1:0] data_d  [NCH];
  logic [1:0]   dest;
  logic         wr_fire;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  assign dest = ptr_q;

  // Pointer only moves on an accepted word, so a stalled channel holds the stream.
  always_comb begin
    ptr_d = ptr_q;
    if (wr_fire) ptr_d = ptr_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`else
  assign dest = S;
`endif

  always_comb begin
    valid = '0;
    for (int unsigned k = 0; k < NCH; k++) valid[k] = (state_q[k] == FULL);
  end

  // A full channel can still accept when its consumer drains it in the same cycle.
  always_comb begin
    in_ready = ~valid[dest] | ack[dest];
    wr_fire  = in_valid & in_ready;
  end

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        EMPTY: begin
          if (wr_fire && (dest == 2'(k))) begin
            state_d[k] = FULL;
            data_d[k]  = X;
          end
        end
        FULL: begin
          if (wr_fire && (dest == 2'(k))) begin
            state_d[k] = FULL;
            data_d[k]  = X;
          end else if (ack[k]) begin
            state_d[k] = EMPTY;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign A = data_q[0];
  assign B = data_q[1];
  assign C = data_q[2];
  assign D = data_q[3];

endmodule

// File: tb/tb_demux_1_to_4_nb.sv
// Bench for demux_1_to_4_nb: directed steps then random traffic against a queue-free channel model.
// Honours DEMUX_ROUND_ROBIN_EN the same way the design does.
module tb_demux_1_to_4_nb;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] X;
  logic [1:0]   S;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B, C, D;
  logic [3:0]   valid;
  logic [3:0]   ack;

  int checks = 0;
  int errors = 0;

  // Reference model: what each consumer would see, plus the round-robin pointer.
  logic [N-1:0] m_data [4];
  bit           m_full [4];
  int           m_ptr;

  demux_1_to_4_nb #(.N(N)) dut (
    .clk(clk), .rst(rst), .X(X), .S(S), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D), .valid(valid), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int m_dest();
`ifdef DEMUX_ROUND_ROBIN_EN
    return m_ptr;
`else
    return int'(S);
`endif
  endfunction

  function automatic bit m_ready();
    int d;
    d = m_dest();
    return !m_full[d] || ack[d];
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  task automatic drive(input bit r, input logic [N-1:0] x, input logic [1:0] s,
                       input bit iv, input logic [3:0] ak);
    rst = r; X = x; S = s; in_valid = iv; ack = ak;
    #1;
    if (!r) check("in_ready", 32'(in_ready), 32'(m_ready()));
  endtask

  // Advance one edge; the model applies the same inputs the DUT samples.
  task automatic tick();
    logic [N-1:0] nd [4];
    bit           nf [4];
    int           d, np;
    bit           fire;
    d = m_dest();
    fire = in_valid && m_ready();
    np = m_ptr;
    for (int k = 0; k < 4; k++) begin
      nd[k] = m_data[k];
      nf[k] = m_full[k];
      if (rst) begin
        nd[k] = '0;
        nf[k] = 1'b0;
      end else if (fire && d == k) begin
        nd[k] = X;
        nf[k] = 1'b1;
      end else if (ack[k]) begin
        nf[k] = 1'b0;
      end
    end
    if (rst) np = 0;
    else if (fire) np = (m_ptr + 1) % 4;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      m_data[k] = nd[k];
      m_full[k] = nf[k];
    end
    m_ptr = np;
    check("A", 32'(A), 32'(m_data[0]));
    check("B", 32'(B), 32'(m_data[1]));
    check("C", 32'(C), 32'(m_data[2]));
    check("D", 32'(D), 32'(m_data[3]));
    check("valid", 32'(valid), 32'(m_valid()));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_data[k] = '0;
      m_full[k] = 1'b0;
    end
    m_ptr = 0;
    rst = 1'b1; X = '0; S = '0; in_valid = 1'b0; ack = '0;
    @(negedge clk);

    // Reset wins over a simultaneous write and acks
    drive(1'b1, 4'hF, 2'b00, 1'b1, 4'hF);
    tick();
    check("rst_A", 32'(A), 32'h0);
    check("rst_D", 32'(D), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    drive(1'b0, 4'h0, 2'b00, 1'b0, 4'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

`ifndef DEMUX_ROUND_ROBIN_EN
    drive(1'b0, 4'h3, 2'b00, 1'b1, 4'h0); tick();
    drive(1'b0, 4'h5, 2'b01, 1'b1, 4'h0); tick();
    drive(1'b0, 4'h9, 2'b10, 1'b1, 4'h0); tick();
    drive(1'b0, 4'hC, 2'b11, 1'b1, 4'h0); tick();
    check("route_A", 32'(A), 32'h3);
    check("route_B", 32'(B), 32'h5);
    check("route_C", 32'(C), 32'h9);
    check("route_D", 32'(D), 32'hC);
    check("route_valid", 32'(valid), 32'hF);

    // Stall on full C, then release with ack in the same cycle
    drive(1'b0, 4'h7, 2'b10, 1'b1, 4'h0);
    check("stall_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("stall_C", 32'(C), 32'h9);
    drive(1'b0, 4'h7, 2'b10, 1'b1, 4'h4);
    check("release_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("release_C", 32'(C), 32'h7);
    check("release_valid2", 32'(valid[2]), 32'h1);

    drive(1'b0, 4'hA, 2'b01, 1'b1, 4'h2); tick();
    check("collide_B", 32'(B), 32'hA);
    check("collide_valid1", 32'(valid[1]), 32'h1);

    drive(1'b0, 4'h0, 2'b00, 1'b0, 4'h8); tick();
    check("drain_valid", 32'(valid), 32'h7);
    drive(1'b0, 4'h0, 2'b00, 1'b0, 4'h8); tick();
    check("ackempty_valid", 32'(valid), 32'h7);
    check("ackempty_D", 32'(D), 32'hC);
    check("ackempty_A", 32'(A), 32'h3);
`else
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 4'(i), 2'b11, 1'b1, 4'hF);
      tick();
    end
    check("rr_A", 32'(A), 32'h5);
    check("rr_B", 32'(B), 32'h2);
    check("rr_C", 32'(C), 32'h3);
    check("rr_D", 32'(D), 32'h4);
    check("rr_valid", 32'(valid), 32'h1);
`endif

    // Random traffic, with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0), 4'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
